// File: rtl/fptd_iter_ctrl.sv
// ============================================================================
// Module      : fptd_iter_ctrl
// Description : Iteration controller for the pipelined FPTD section array.
//               Sequences even/odd phases, replays phases on razor errors,
//               counts bit errors per iteration and terminates the frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fptd_iter_ctrl #(
    parameter int K       = 64,
    parameter int ITER_W  = 6,
    parameter int ZSTOP_W = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     start,
    input  logic [ITER_W-1:0]        max_iter,
    input  logic [ZSTOP_W-1:0]       zstop,
    input  logic [K-1:0]             b1_error,
    input  logic [K-1:0]             razor_err,
    output logic                     Enable,
    output logic                     nClear,
    output logic                     busy,
    output logic                     err_valid,
    output logic [$clog2(K+1)-1:0]   err_count,
    output logic [ITER_W-1:0]        iter_cnt,
    output logic [15:0]              razor_cnt,
    output logic                     done
);

    localparam int c_CNT_W = $clog2(K+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ITER_W-1:0]    r_max_iter;
    logic [ZSTOP_W-1:0]   r_zstop;
    logic [ZSTOP_W-1:0]   r_run;

    logic [c_CNT_W-1:0]   w_pop;
    logic                 w_razor;
    logic [ITER_W-1:0]    w_iter_next;
    logic [ZSTOP_W-1:0]   w_run_next;
    logic                 w_term;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < K; i++) begin
            w_pop = w_pop + c_CNT_W'(b1_error[i]);
        end
    end

    assign w_razor     = |razor_err;
    assign w_iter_next = iter_cnt + 1'b1;

    // Zero-error run length saturates so it cannot wrap when the stop is disabled
    always_comb begin
        w_run_next = '0;
        if (w_pop == '0) begin
            w_run_next = (r_run == {ZSTOP_W{1'b1}}) ? r_run : r_run + 1'b1;
        end
    end

    assign w_term = (w_iter_next == r_max_iter) ||
                    ((r_zstop != '0) && (w_run_next == r_zstop));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_max_iter <= '0;
            r_zstop    <= '0;
            r_run      <= '0;
            Enable     <= 1'b0;
            nClear     <= 1'b1;
            busy       <= 1'b0;
            err_valid  <= 1'b0;
            err_count  <= '0;
            iter_cnt   <= '0;
            razor_cnt  <= '0;
            done       <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    Enable    <= 1'b0;
                    nClear    <= 1'b1;
                    busy      <= 1'b0;
                    razor_cnt <= '0;
                    if (start) begin
                        r_max_iter <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                        r_zstop    <= zstop;
                        r_run      <= '0;
                        iter_cnt   <= '0;
                        busy       <= 1'b1;
                        nClear     <= 1'b0;
                        r_state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    nClear  <= 1'b1;
                    Enable  <= 1'b1;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_razor) begin
                        if (razor_cnt != 16'hFFFF) begin
                            razor_cnt <= razor_cnt + 16'd1;
                        end
                    end else if (!Enable) begin
                        // Completed odd phase: the sections' b1_error is sampled here
                        err_count <= w_pop;
                        iter_cnt  <= w_iter_next;
                        err_valid <= 1'b1;
                        r_run     <= w_run_next;
                        if (w_term) begin
                            Enable  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            Enable  <= 1'b1;
                        end
                    end else begin
                        Enable <= 1'b0;
                    end
                end
                S_DONE: begin
                    Enable  <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
